// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-lite interconnect: FSM encoding, prot values and
// the default system memory map.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWFwd,
        StWResp,
        StRFwd,
        StRResp,
        StMB,
        StMR
    } axi_state_e;

    localparam logic [2:0] AXI_PROT_DEFAULT    = 3'b000;
    localparam logic [2:0] AXI_PROT_PRIV       = 3'b001;
    localparam logic [2:0] AXI_PROT_NONSECURE  = 3'b010;
    localparam logic [2:0] AXI_PROT_INSTR      = 3'b100;

    localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] UART_BASE = 32'h2000_0000;
    localparam logic [31:0] GPIO_BASE = 32'h3000_0000;
    localparam logic [31:0] MAP_MASK  = 32'hF000_0000;

    localparam logic [127:0] DEFAULT_BASE_ADDRS = {GPIO_BASE, UART_BASE, RAM_BASE, ROM_BASE};
    localparam logic [127:0] DEFAULT_ADDR_MASKS = {4{MAP_MASK}};

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder: lowest-index matching region wins, no match flags a miss.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int unsigned              N_SLAVES   = 4,
    parameter logic [N_SLAVES*32-1:0]   BASE_ADDRS = DEFAULT_BASE_ADDRS,
    parameter logic [N_SLAVES*32-1:0]   ADDR_MASKS = DEFAULT_ADDR_MASKS
) (
    input  logic [31:0]          i_addr,
    output logic [N_SLAVES-1:0]  o_sel,
    output logic                 o_miss
);

    always_comb begin
        o_sel  = '0;
        o_miss = 1'b1;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (o_miss && ((i_addr & ADDR_MASKS[i*32 +: 32]) == BASE_ADDRS[i*32 +: 32])) begin
                o_sel[i] = 1'b1;
                o_miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_interconnect.sv
// Single-master, N-slave AXI4-lite router with one outstanding transaction,
// unmapped-address completion, hung-slave timeout and error capture.
module axi_lite_interconnect
    import axi_lite_pkg::*;
#(
    parameter int unsigned              N_SLAVES      = 4,
    parameter logic [N_SLAVES*32-1:0]   BASE_ADDRS    = DEFAULT_BASE_ADDRS,
    parameter logic [N_SLAVES*32-1:0]   ADDR_MASKS    = DEFAULT_ADDR_MASKS,
    parameter int unsigned              TIMEOUT       = 1023,
    parameter logic [31:0]              DEFAULT_RDATA = 32'hDEAD_BEEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    m_awvalid,
    output logic                    m_awready,
    input  logic [31:0]             m_awaddr,
    input  logic [2:0]              m_awprot,
    input  logic                    m_wvalid,
    output logic                    m_wready,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_wstrb,
    output logic                    m_bvalid,
    input  logic                    m_bready,
    input  logic                    m_arvalid,
    output logic                    m_arready,
    input  logic [31:0]             m_araddr,
    input  logic [2:0]              m_arprot,
    output logic                    m_rvalid,
    input  logic                    m_rready,
    output logic [31:0]             m_rdata,
    output logic [N_SLAVES-1:0]     s_awvalid,
    input  logic [N_SLAVES-1:0]     s_awready,
    output logic [31:0]             s_awaddr,
    output logic [2:0]              s_awprot,
    output logic [N_SLAVES-1:0]     s_wvalid,
    input  logic [N_SLAVES-1:0]     s_wready,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    input  logic [N_SLAVES-1:0]     s_bvalid,
    output logic [N_SLAVES-1:0]     s_bready,
    output logic [N_SLAVES-1:0]     s_arvalid,
    input  logic [N_SLAVES-1:0]     s_arready,
    output logic [31:0]             s_araddr,
    output logic [2:0]              s_arprot,
    input  logic [N_SLAVES-1:0]     s_rvalid,
    output logic [N_SLAVES-1:0]     s_rready,
    input  logic [N_SLAVES*32-1:0]  s_rdata,
    output logic                    err_decode,
    output logic                    err_timeout,
    output logic [31:0]             err_addr
);

    localparam int unsigned TW = $clog2(TIMEOUT + 2);

    axi_state_e             r_state, w_state_nxt;
    logic [31:0]            r_addr, r_wdata, r_rdata, r_err_addr;
    logic [2:0]             r_prot;
    logic [3:0]             r_wstrb;
    logic [N_SLAVES-1:0]    r_sel;
    logic                   r_aw_pend, r_w_pend;
    logic [TW-1:0]          r_tcnt;
    logic                   r_err_decode, r_err_timeout;

    logic                   w_acc_wr, w_acc_rd, w_dec_miss, w_in_slave, w_timeout;
    logic                   w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [31:0]            w_dec_addr, w_rdata_sel;
    logic [N_SLAVES-1:0]    w_dec_sel;

    // Writes win over reads; nothing is accepted while reset is held.
    assign w_acc_wr   = (r_state == StIdle) && !RST && m_awvalid && m_wvalid;
    assign w_acc_rd   = (r_state == StIdle) && !RST && !(m_awvalid && m_wvalid) && m_arvalid;
    assign w_dec_addr = w_acc_wr ? m_awaddr : m_araddr;

    axi_lite_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .BASE_ADDRS (BASE_ADDRS),
        .ADDR_MASKS (ADDR_MASKS)
    ) u_addr_decode (
        .i_addr (w_dec_addr),
        .o_sel  (w_dec_sel),
        .o_miss (w_dec_miss)
    );

    assign w_in_slave = (r_state == StWFwd) || (r_state == StWResp) ||
                        (r_state == StRFwd) || (r_state == StRResp);
    assign w_timeout  = (TIMEOUT != 0) && w_in_slave && (r_tcnt == TW'(TIMEOUT));

    // Abandoning a hung slave drops its valid/ready in the same cycle the timeout fires.
    always_comb begin
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        s_arvalid = '0;
        s_rready  = '0;
        if (!w_timeout) begin
            if (r_state == StWFwd && r_aw_pend) s_awvalid = r_sel;
            if (r_state == StWFwd && r_w_pend)  s_wvalid  = r_sel;
            if (r_state == StWResp)             s_bready  = r_sel;
            if (r_state == StRFwd)              s_arvalid = r_sel;
            if (r_state == StRResp)             s_rready  = r_sel;
        end
    end

    assign w_aw_hs = |(s_awvalid & s_awready);
    assign w_w_hs  = |(s_wvalid & s_wready);
    assign w_b_hs  = |(s_bready & s_bvalid);
    assign w_ar_hs = |(s_arvalid & s_arready);
    assign w_r_hs  = |(s_rready & s_rvalid);

    always_comb begin
        w_rdata_sel = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (r_sel[i]) w_rdata_sel = w_rdata_sel | s_rdata[i*32 +: 32];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_acc_wr)      w_state_nxt = w_dec_miss ? StMB : StWFwd;
                else if (w_acc_rd) w_state_nxt = w_dec_miss ? StMR : StRFwd;
            end
            StWFwd: begin
                if (w_timeout) w_state_nxt = StMB;
                else if ((!r_aw_pend || w_aw_hs) && (!r_w_pend || w_w_hs)) w_state_nxt = StWResp;
            end
            StWResp: if (w_timeout || w_b_hs)  w_state_nxt = StMB;
            StRFwd: begin
                if (w_timeout)    w_state_nxt = StMR;
                else if (w_ar_hs) w_state_nxt = StRResp;
            end
            StRResp: if (w_timeout || w_r_hs)  w_state_nxt = StMR;
            StMB:    if (m_bready)             w_state_nxt = StIdle;
            StMR:    if (m_rready)             w_state_nxt = StIdle;
            default:                           w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_prot        <= '0;
            r_rdata       <= '0;
            r_err_addr    <= '0;
            r_sel         <= '0;
            r_aw_pend     <= 1'b0;
            r_w_pend      <= 1'b0;
            r_tcnt        <= '0;
            r_err_decode  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_err_decode  <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_acc_wr || w_acc_rd) begin
                r_addr    <= w_dec_addr;
                r_prot    <= w_acc_wr ? m_awprot : m_arprot;
                r_sel     <= w_dec_sel;
                r_aw_pend <= w_acc_wr;
                r_w_pend  <= w_acc_wr;
                r_tcnt    <= '0;
                if (w_acc_wr) begin
                    r_wdata <= m_wdata;
                    r_wstrb <= m_wstrb;
                end
                if (w_dec_miss) begin
                    r_err_decode <= 1'b1;
                    r_err_addr   <= w_dec_addr;
                    r_rdata      <= DEFAULT_RDATA;
                end
            end else begin
                if (w_in_slave) r_tcnt    <= r_tcnt + TW'(1);
                if (w_aw_hs)    r_aw_pend <= 1'b0;
                if (w_w_hs)     r_w_pend  <= 1'b0;
                if (w_r_hs)     r_rdata   <= w_rdata_sel;
                if (w_timeout) begin
                    r_err_timeout <= 1'b1;
                    r_err_addr    <= r_addr;
                    r_rdata       <= DEFAULT_RDATA;
                end
            end
        end
    end

    assign m_awready   = w_acc_wr;
    assign m_wready    = w_acc_wr;
    assign m_arready   = w_acc_rd;
    assign m_bvalid    = (r_state == StMB);
    assign m_rvalid    = (r_state == StMR);
    assign m_rdata     = r_rdata;
    assign s_awaddr    = r_addr;
    assign s_araddr    = r_addr;
    assign s_awprot    = r_prot;
    assign s_arprot    = r_prot;
    assign s_wdata     = r_wdata;
    assign s_wstrb     = r_wstrb;
    assign err_decode  = r_err_decode;
    assign err_timeout = r_err_timeout;
    assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_axi_lite_interconnect.sv
// Bench for axi_lite_interconnect: behavioural slaves, scoreboard of expected master
// responses, and directed read/write/miss/timeout/priority/reset scenarios.
module tb_axi_lite_interconnect;
    import axi_lite_pkg::*;

    localparam int NS         = 4;
    localparam int TB_TIMEOUT = 8;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
    } sb_item_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic m_awvalid = 0, m_wvalid = 0, m_arvalid = 0, m_bready = 1, m_rready = 1;
    logic [31:0] m_awaddr = '0, m_wdata = '0, m_araddr = '0;
    logic [2:0] m_awprot = '0, m_arprot = '0;
    logic [3:0] m_wstrb = '0;
    logic m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [31:0] m_rdata, s_awaddr, s_wdata, s_araddr, err_addr;
    logic [2:0] s_awprot, s_arprot;
    logic [3:0] s_wstrb;
    logic [NS-1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [NS-1:0] s_awready = '0, s_wready = '0, s_bvalid = '0, s_arready = '0, s_rvalid = '0;
    logic [NS*32-1:0] s_rdata = '0;
    logic err_decode, err_timeout;

    int n_chk = 0, n_err = 0, cyc = 0;
    sb_item_t sb_q[$];

    int aw_lat[NS], w_lat[NS], r_lat[NS], aw_cnt[NS], w_cnt[NS], r_cnt[NS];
    bit hang[NS], got_aw[NS], got_w[NS], b_pend[NS], r_pend[NS];
    logic [31:0] rdata_cfg[NS], cap_awaddr[NS], cap_wdata[NS];
    logic [3:0] cap_wstrb[NS];
    int arv_cyc[NS], awv_cyc[NS];
    int n_dec = 0, n_to = 0;

    axi_lite_interconnect #(.TIMEOUT(TB_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .err_decode(err_decode), .err_timeout(err_timeout), .err_addr(err_addr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_slaves();
        for (int i = 0; i < NS; i++) begin
            aw_lat[i] = 0; w_lat[i] = 0; r_lat[i] = 0;
            aw_cnt[i] = 0; w_cnt[i] = 0; r_cnt[i] = 0;
            hang[i] = 0; got_aw[i] = 0; got_w[i] = 0; b_pend[i] = 0; r_pend[i] = 0;
            rdata_cfg[i] = 32'h0101_0101 * (i + 1);
            arv_cyc[i] = 0; awv_cyc[i] = 0;
        end
    endtask

    // Slave models: drive at the falling edge from the DUT outputs settled since the rising edge.
    initial begin
        reset_slaves();
        forever begin
            @(negedge CLK);
            if (err_decode) n_dec++;
            if (err_timeout) n_to++;
            for (int i = 0; i < NS; i++) begin
                if (s_arvalid[i]) arv_cyc[i]++;
                if (s_awvalid[i]) awv_cyc[i]++;
                s_awready[i] = s_awvalid[i] && (aw_cnt[i] >= aw_lat[i]);
                aw_cnt[i]    = s_awvalid[i] ? aw_cnt[i] + 1 : 0;
                s_wready[i]  = s_wvalid[i] && (w_cnt[i] >= w_lat[i]);
                w_cnt[i]     = s_wvalid[i] ? w_cnt[i] + 1 : 0;
                s_arready[i] = s_arvalid[i];
                s_bvalid[i]  = b_pend[i];
                s_rvalid[i]  = r_pend[i] && !hang[i] && (r_cnt[i] >= r_lat[i]);
                s_rdata[i*32 +: 32] = rdata_cfg[i];
                if (r_pend[i]) r_cnt[i]++;
                if (s_awvalid[i] && s_awready[i]) begin
                    got_aw[i] = 1; cap_awaddr[i] = s_awaddr;
                end
                if (s_wvalid[i] && s_wready[i]) begin
                    got_w[i] = 1; cap_wdata[i] = s_wdata; cap_wstrb[i] = s_wstrb;
                end
                if (b_pend[i] && s_bready[i]) b_pend[i] = 0;
                if (got_aw[i] && got_w[i]) begin
                    got_aw[i] = 0; got_w[i] = 0; b_pend[i] = 1;
                end
                if (s_rvalid[i] && s_rready[i]) r_pend[i] = 0;
                if (s_arvalid[i] && s_arready[i]) begin
                    r_pend[i] = 1; r_cnt[i] = 0;
                end
            end
        end
    end

    // All master tasks start and end just after a falling edge.
    task automatic start_read(input logic [31:0] addr, input logic [31:0] exp, output int acc);
        int n = 0;
        m_araddr = addr; m_arprot = AXI_PROT_PRIV; m_arvalid = 1;
        sb_q.push_back('{is_wr: 1'b0, data: exp});
        #1;
        while (!m_arready && n < 64) begin @(negedge CLK); #1; n++; end
        check("ar_accept", {31'b0, m_arready}, 1);
        acc = cyc;
        @(negedge CLK);
        m_arvalid = 0;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output int acc);
        int n = 0;
        m_awaddr = addr; m_awprot = AXI_PROT_NONSECURE; m_wdata = data; m_wstrb = strb;
        m_awvalid = 1; m_wvalid = 1;
        sb_q.push_back('{is_wr: 1'b1, data: 32'h0});
        #1;
        while (!m_awready && n < 64) begin @(negedge CLK); #1; n++; end
        check("aw_w_accept", {30'b0, m_awready, m_wready}, 3);
        acc = cyc;
        @(negedge CLK);
        m_awvalid = 0; m_wvalid = 0;
    endtask

    task automatic get_resp(input bit is_wr, output int rcyc);
        int n = 0;
        sb_item_t e;
        #1;
        while (!(is_wr ? m_bvalid : m_rvalid) && n < 64) begin @(negedge CLK); #1; n++; end
        rcyc = cyc;
        check(is_wr ? "bvalid_seen" : "rvalid_seen", {31'b0, is_wr ? m_bvalid : m_rvalid}, 1);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("resp_kind", {31'b0, is_wr}, {31'b0, e.is_wr});
            if (!is_wr) check("rdata", m_rdata, e.data);
        end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int acc, rc, bc, cnt, d0, t0, n;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_m_ctrl", {27'b0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 0);
        check("rst_s_ctrl", {12'b0, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
        check("rst_err_pulses", {30'b0, err_decode, err_timeout}, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_m_rdata", m_rdata, 0);
        RST = 0;
        @(negedge CLK);

        // Zero-wait read hit on slave 1
        reset_slaves();
        rdata_cfg[1] = 32'h1234_5678;
        start_read(32'h1000_0004, 32'h1234_5678, acc);
        get_resp(0, rc);
        check("rd_latency", rc - acc, 3);
        check("rd_arvalid1_cycles", arv_cyc[1], 1);
        check("rd_other_arvalid", arv_cyc[0] + arv_cyc[2] + arv_cyc[3], 0);
        check("rd_araddr", s_araddr, 32'h1000_0004);
        check("rd_arprot", {29'b0, s_arprot}, {29'b0, AXI_PROT_PRIV});

        // Write to slave 2, W accepted two cycles after AW, B held by master
        reset_slaves();
        w_lat[2] = 2;
        m_bready = 0;
        start_write(32'h2000_0000, 32'hA5A5_A5A5, 4'b0011, acc);
        n = 0;
        #1;
        while (!m_bvalid && n < 64) begin @(negedge CLK); #1; n++; end
        cnt = 0;
        for (int k = 0; k < 3; k++) begin @(negedge CLK); #1; if (m_bvalid) cnt++; end
        check("wr_b_hold", cnt, 3);
        m_bready = 1;
        get_resp(1, bc);
        #1;
        check("wr_b_single", {31'b0, m_bvalid}, 0);
        check("wr_wdata", cap_wdata[2], 32'hA5A5_A5A5);
        check("wr_wstrb", {28'b0, cap_wstrb[2]}, 32'h3);
        check("wr_awaddr", cap_awaddr[2], 32'h2000_0000);
        check("wr_awvalid_once", awv_cyc[2], 1);
        check("wr_other_awvalid", awv_cyc[0] + awv_cyc[1] + awv_cyc[3], 0);
        @(negedge CLK);

        // Unmapped read
        reset_slaves();
        d0 = n_dec;
        start_read(32'h5000_0000, 32'hDEAD_BEEF, acc);
        get_resp(0, rc);
        check("miss_err_decode", n_dec - d0, 1);
        check("miss_err_addr", err_addr, 32'h5000_0000);
        check("miss_no_arvalid", arv_cyc[0] + arv_cyc[1] + arv_cyc[2] + arv_cyc[3], 0);

        // Slave 0 never answers; timeout recovers, then slave 1 still works
        reset_slaves();
        hang[0] = 1;
        t0 = n_to;
        start_read(32'h0000_0100, 32'hDEAD_BEEF, acc);
        get_resp(0, rc);
        check("to_latency_window",
              {31'b0, (rc - acc >= TB_TIMEOUT + 1) && (rc - acc <= TB_TIMEOUT + 3)}, 1);
        check("to_err_timeout", n_to - t0, 1);
        check("to_err_addr", err_addr, 32'h0000_0100);
        check("to_rready_dropped", {31'b0, s_rready[0]}, 0);
        reset_slaves();
        rdata_cfg[1] = 32'hCAFE_0001;
        start_read(32'h1000_0008, 32'hCAFE_0001, acc);
        get_resp(0, rc);
        check("to_next_latency", rc - acc, 3);

        // Simultaneous write and read: write first, read accepted once back in idle
        reset_slaves();
        rdata_cfg[0] = 32'h0C0F_FEE0;
        m_awaddr = 32'h3000_0010; m_wdata = 32'h0BAD_F00D; m_wstrb = 4'hF;
        m_araddr = 32'h0000_0020;
        m_awvalid = 1; m_wvalid = 1; m_arvalid = 1;
        sb_q.push_back('{is_wr: 1'b1, data: 32'h0});
        sb_q.push_back('{is_wr: 1'b0, data: 32'h0C0F_FEE0});
        #1;
        check("prio_write_first", {30'b0, m_awready, m_arready}, 2);
        @(negedge CLK);
        m_awvalid = 0; m_wvalid = 0;
        get_resp(1, bc);
        #1;
        check("prio_read_accept", {31'b0, m_arready}, 1);
        check("prio_read_cycle", cyc - bc, 1);
        check("prio_wdata", cap_wdata[3], 32'h0BAD_F00D);
        @(negedge CLK);
        m_arvalid = 0;
        get_resp(0, rc);

        // Reset while waiting in R_RESP
        reset_slaves();
        r_lat[1] = 5;
        start_read(32'h1000_000C, 32'h0, acc);
        n = 0;
        #1;
        while (!s_rready[1] && n < 64) begin @(negedge CLK); #1; n++; end
        check("rst_mid_in_resp", {31'b0, s_rready[1]}, 1);
        RST = 1;
        @(negedge CLK);
        #1;
        check("rst_mid_m_ctrl", {27'b0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 0);
        check("rst_mid_s_ctrl", {12'b0, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
        check("rst_mid_err_addr", err_addr, 0);
        check("rst_mid_m_rdata", m_rdata, 0);
        RST = 0;
        void'(sb_q.pop_front());
        reset_slaves();
        rdata_cfg[1] = 32'h7777_1111;
        @(negedge CLK);
        start_read(32'h1000_000C, 32'h7777_1111, acc);
        get_resp(0, rc);
        check("rst_after_latency", rc - acc, 3);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_lite_interconnect.md
Name: axi_lite_interconnect

Overview:
- Single-master, N-slave AXI4-lite address decoder and router between the picorv32 AXI master and peripheral slaves (memory controller, UART, GPIO, audio, display).
- Generalised successor to the fixed one-slave hookup:
  - parametrised slave count and address map;
  - unmapped-address completion;
  - per-transaction timeout against hung slaves;
  - error capture.
- One outstanding transaction. Reads and writes are serialised.

Parameters:
- N_SLAVES, 4, number of slave ports (1..8).
- BASE_ADDRS, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, flattened N_SLAVES×32 bases; slave i in bits [32i+31:32i].
- ADDR_MASKS, {4{32'hF000_0000}}, flattened N_SLAVES×32 masks. Slave i matches when (addr & mask_i) == base_i.
- TIMEOUT, 1023, slave cycles before abandon; 0 disables the timeout.
- DEFAULT_RDATA, 32'hDEAD_BEEF, read data returned on decode error or timeout.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- m_awvalid in 1, m_awready out 1, m_awaddr in 32, m_awprot in 3  master write address
- m_wvalid in 1, m_wready out 1, m_wdata in 32, m_wstrb in 4  master write data
- m_bvalid out 1, m_bready in 1  master write response
- m_arvalid in 1, m_arready out 1, m_araddr in 32, m_arprot in 3  master read address
- m_rvalid out 1, m_rready in 1, m_rdata out 32  master read data
- s_awvalid out N, s_awready in N, s_awaddr out 32, s_awprot out 3  per-slave valid/ready; address and prot broadcast
- s_wvalid out N, s_wready in N, s_wdata out 32, s_wstrb out 4
- s_bvalid in N, s_bready out N
- s_arvalid out N, s_arready in N, s_araddr out 32, s_arprot out 3
- s_rvalid in N, s_rready out N, s_rdata in N×32
- err_decode out 1  one-cycle pulse on an unmapped access
- err_timeout out 1  one-cycle pulse on timeout
- err_addr out 32  address of the most recent error

Behaviour:
- Clock and reset: all logic on CLK rising edge. RST is synchronous and active-high.
- Reset values: all valid/ready outputs and error pulses = 0; err_addr = 0; m_rdata = 0; state = IDLE; timeout counter = 0.
- Reset asserted mid-transaction aborts it; all slave valids drop the next cycle.
- States: IDLE, W_FWD, W_RESP, R_FWD, R_RESP, M_B, M_R.
- IDLE:
  - Write has priority: it requires m_awvalid && m_wvalid both high.
  - Otherwise, m_arvalid starts a read.
  - Accept: assert m_awready+m_wready (or m_arready) for exactly one cycle.
  - Latch addr/prot/data/strb.
  - Register the decode: lowest-index matching slave wins; a miss sets a miss flag.
- Write path:
  - Hit → W_FWD. Drive s_awvalid[sel] and s_wvalid[sel]; each drops independently after its handshake.
  - When both handshakes are done → W_RESP with s_bready[sel]=1.
  - s_bvalid[sel] → M_B.
- Read path:
  - Hit → R_FWD with s_arvalid[sel]. After handshake → R_RESP with s_rready[sel]=1.
  - s_rvalid[sel]: capture s_rdata[sel] into m_rdata → M_R.
- Miss:
  - Go directly to M_B or M_R; m_rdata = DEFAULT_RDATA.
  - Pulse err_decode; err_addr = latched address.
  - No slave valid is asserted.
- M_B / M_R: hold m_bvalid / m_rvalid with m_rdata stable until m_bready / m_rready, then IDLE. The next acceptance comes one cycle later at the earliest.
- Timeout:
  - The counter clears on entry to W_FWD/R_FWD and counts every cycle in the FWD/RESP states.
  - When it equals TIMEOUT (and TIMEOUT≠0): drop all slave valids/readies, pulse err_timeout, set err_addr, go to M_B/M_R with m_rdata = DEFAULT_RDATA.
  - This deliberately violates AXI toward the hung slave; it is recovery only.
- Minimum latency, hit, zero-wait slave: accept at cycle 0, slave valid at cycle 1, response at the master at cycle 3.
- Slave-side outputs s_awaddr/s_araddr/s_wdata are registered and stable while the slave valid is high.
- Stray slave responses (s_bvalid/s_rvalid on a non-selected index, or outside a RESP state) are ignored.

Decomposition:
- Shared package axi_lite_pkg:
  - state encoding constants;
  - AXI prot constants;
  - default map bases/masks for the system memory map (ROM, RAM 0x1000_0000, UART, GPIO).
- Sub-module axi_lite_addr_decode: purely combinational; address + parameters → one-hot select and miss. Reusable by the future display/audio DMA masters.

Test Plan:
- Read 0x1000_0004, slave 1 returns 32'h1234_5678 with zero wait → m_rvalid at cycle 3, m_rdata=32'h1234_5678; only s_arvalid[1] ever asserted.
- Write 0x2000_0000, data 32'hA5A5_A5A5, strb 4'b0011; slave 2 gives s_wready 2 cycles after s_awready → s_wdata/s_wstrb match, one m_bvalid pulse held until m_bready.
- Read 0x5000_0000 (unmapped) → m_rdata=32'hDEAD_BEEF, err_decode pulses once, err_addr=32'h5000_0000, no s_arvalid.
- TIMEOUT=8; slave 0 never asserts s_rvalid → after 8 cycles, s_rready[0] drops, err_timeout pulses, m_rdata=DEAD_BEEF, the next read to slave 1 succeeds.
- m_awvalid+m_wvalid+m_arvalid together at IDLE → write serviced first, read accepted the cycle after IDLE re-entry.
- RST high while in R_RESP → the next cycle all outputs are at reset values; a subsequent read completes normally.
